// File: rtl/arm_pipe_pkg.sv
// Shared pipeline-control types: forwarding select encoding and the
// per-stage scoreboard entry tracked by hazard_ctrl.
package arm_pipe_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             vld;
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             mem_r;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX control point and hazard_ctrl: ID operand
// information, EXE/MEM status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_vld;
    logic             id_src2_vld;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             exe_branch_taken;
    logic             mem_busy;
    logic             if_id_freeze;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_src1, id_src2, id_src1_vld, id_src2_vld,
               id_dest, id_wb_en, id_mem_r_en, exe_branch_taken, mem_busy,
        input  if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze,
               sel_src1, sel_src2, stall_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_src1_vld, id_src2_vld,
               id_dest, id_wb_en, id_mem_r_en, exe_branch_taken, mem_busy,
        output if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze,
               sel_src1, sel_src2, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sb_match.sv
// sb_match: compares one ID source register against one scoreboard slot.
// load_only restricts the hit to producers that are loads.
module sb_match
    import arm_pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             src_vld,
    input  sb_entry_t        slot,
    input  logic             load_only,
    output logic             hit
);

    assign hit = slot.vld & slot.wb_en & src_vld & (src == slot.dest)
               & (slot.mem_r | ~load_only);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID freeze, ID/EX bubble, branch flush and memory-wait
// freeze around the ID/EX register, driven by a two-slot (EXE, MEM)
// scoreboard of in-flight destinations.
// Optional feature macro FORWARDING_EN: stall only on load-use and emit
// registered forwarding selects aligned with the ID/EX register outputs.
module hazard_ctrl #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    import arm_pipe_pkg::*;

    sb_entry_t        ex_slot;
    sb_entry_t        mem_slot;
    sb_entry_t        id_entry;
    logic [CNT_W-1:0] stall_q;
    logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic             hazard;
    logic             bubble;
    logic             frozen;

    sb_match u_ex_src1 (.src(hz.id_src1), .src_vld(hz.id_src1_vld), .slot(ex_slot),
                        .load_only(1'b0), .hit(ex_hit1));
    sb_match u_ex_src2 (.src(hz.id_src2), .src_vld(hz.id_src2_vld), .slot(ex_slot),
                        .load_only(1'b0), .hit(ex_hit2));
    sb_match u_mem_src1 (.src(hz.id_src1), .src_vld(hz.id_src1_vld), .slot(mem_slot),
                         .load_only(1'b0), .hit(mem_hit1));
    sb_match u_mem_src2 (.src(hz.id_src2), .src_vld(hz.id_src2_vld), .slot(mem_slot),
                         .load_only(1'b0), .hit(mem_hit2));

`ifdef FORWARDING_EN
    // Only a load still in EXE cannot be forwarded in time.
    assign hazard = (ex_hit1 | ex_hit2) & ex_slot.mem_r;
`else
    assign hazard = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
`endif

    assign frozen   = hz.mem_busy;
    assign bubble   = hz.exe_branch_taken | hazard;
    assign id_entry = '{vld: 1'b1, wb_en: hz.id_wb_en,
                        dest: hz.id_dest[REG_W-1:0], mem_r: hz.id_mem_r_en};

    // Control outputs by priority: memory wait, branch squash, data hazard.
    always_comb begin
        hz.pipe_freeze  = 1'b0;
        hz.if_id_freeze = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        if (!rst) begin
            if (hz.mem_busy) begin
                hz.pipe_freeze  = 1'b1;
                hz.if_id_freeze = 1'b1;
            end else if (hz.exe_branch_taken) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (hazard) begin
                hz.if_id_freeze = 1'b1;
                hz.id_ex_flush  = 1'b1;
            end
        end
    end

    // Scoreboard advances with the pipe and stall cycles are counted; all hold on memory wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= SB_BUBBLE;
            mem_slot <= SB_BUBBLE;
            stall_q  <= '0;
        end else if (!frozen) begin
            mem_slot <= ex_slot;
            ex_slot  <= bubble ? SB_BUBBLE : id_entry;
            if (hazard && !hz.exe_branch_taken && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_q;

`ifdef FORWARDING_EN
    fwd_sel_t sel1_q;
    fwd_sel_t sel2_q;

    // Forward selects load on the ID/EX edge so they line up with its outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel1_q <= FWD_NONE;
            sel2_q <= FWD_NONE;
        end else if (!frozen) begin
            if (bubble) begin
                sel1_q <= FWD_NONE;
                sel2_q <= FWD_NONE;
            end else begin
                sel1_q <= ex_hit1 ? FWD_MEM : (mem_hit1 ? FWD_WB : FWD_NONE);
                sel2_q <= ex_hit2 ? FWD_MEM : (mem_hit2 ? FWD_WB : FWD_NONE);
            end
        end
    end

    assign hz.sel_src1 = sel1_q;
    assign hz.sel_src2 = sel2_q;
`else
    assign hz.sel_src1 = FWD_NONE;
    assign hz.sel_src2 = FWD_NONE;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a reference model of the in-flight pipeline.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(RW), .CNT_W(CW)) hz ();

    hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: producers in flight, index 0 = EXE, 1 = MEM.
    bit p_live [2];
    bit p_wr   [2];
    bit p_ld   [2];
    int p_reg  [2];
    int m_sel1;
    int m_sel2;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads(input int src, input bit v, input int k);
        return p_live[k] && p_wr[k] && v && (src == p_reg[k]);
    endfunction

    function automatic int sel_of(input int src, input bit v);
        if (reads(src, v, 0)) return 1;
        if (reads(src, v, 1)) return 2;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            p_live[k] = 0; p_wr[k] = 0; p_ld[k] = 0; p_reg[k] = 0;
        end
        m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
    endtask

    task automatic drive(input int s1, input bit v1, input int s2, input bit v2,
                         input int d, input bit wb, input bit ld,
                         input bit br, input bit busy);
        hz.id_src1          = s1[RW-1:0];
        hz.id_src1_vld      = v1;
        hz.id_src2          = s2[RW-1:0];
        hz.id_src2_vld      = v2;
        hz.id_dest          = d[RW-1:0];
        hz.id_wb_en         = wb;
        hz.id_mem_r_en      = ld;
        hz.exe_branch_taken = br;
        hz.mem_busy         = busy;
    endtask

    // One clock: check mid-cycle against the model, then advance model and DUT.
    task automatic step();
        int  s1, s2, d;
        bit  v1, v2, br, busy, r, haz, any_ex, any_mem, bub;
        #4;
        s1 = int'(hz.id_src1); s2 = int'(hz.id_src2); d = int'(hz.id_dest);
        v1 = hz.id_src1_vld; v2 = hz.id_src2_vld;
        br = hz.exe_branch_taken; busy = hz.mem_busy; r = rst;
        any_ex  = reads(s1, v1, 0) || reads(s2, v2, 0);
        any_mem = reads(s1, v1, 1) || reads(s2, v2, 1);
        haz = FWD ? (any_ex && p_ld[0]) : (any_ex || any_mem);

        chk("pipe_freeze",  32'(hz.pipe_freeze),  32'(!r && busy));
        chk("if_id_freeze", 32'(hz.if_id_freeze), 32'(!r && (busy || (!br && haz))));
        chk("if_id_flush",  32'(hz.if_id_flush),  32'(!r && !busy && br));
        chk("id_ex_flush",  32'(hz.id_ex_flush),  32'(!r && !busy && (br || haz)));
        chk("sel_src1",     32'(hz.sel_src1),     32'(m_sel1));
        chk("sel_src2",     32'(hz.sel_src2),     32'(m_sel2));
        chk("stall_cnt",    32'(hz.stall_cnt),    32'(m_cnt));

        if (r) begin
            model_clear();
        end else if (!busy) begin
            bub = br || haz;
            m_sel1 = (bub || !FWD) ? 0 : sel_of(s1, v1);
            m_sel2 = (bub || !FWD) ? 0 : sel_of(s2, v2);
            if (haz && !br && m_cnt < CNT_MAX) m_cnt++;
            p_live[1] = p_live[0]; p_wr[1] = p_wr[0]; p_ld[1] = p_ld[0]; p_reg[1] = p_reg[0];
            p_live[0] = !bub; p_wr[0] = hz.id_wb_en; p_ld[0] = hz.id_mem_r_en; p_reg[0] = d;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_clear();
        step();
        rst = 1'b0;

        // ALU producer R1 in EXE, consumer reads R1 as src1
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0); step();
        drive(1, 1, 0, 0, 2, 1, 0, 0, 0); step();
        chk("fwd_ex_sel1", 32'(hz.sel_src1), FWD ? 32'd1 : 32'd0);
        step(); step();
        chk("raw_stall_cnt", 32'(hz.stall_cnt), FWD ? 32'd0 : 32'd2);

        // Producer R4 one stage further away (MEM)
        drive(0, 0, 0, 0, 4, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(4, 1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("fwd_mem_sel1", 32'(hz.sel_src1), FWD ? 32'd2 : 32'd0);
        step();

        // Load-use: LDR R3 then STR reading R3 as src2
        drive(0, 0, 0, 0, 3, 1, 1, 0, 0); step();
        drive(0, 0, 3, 1, 0, 0, 0, 0, 0); step(); step();
        chk("ldu_sel2", 32'(hz.sel_src2), FWD ? 32'd2 : 32'd0);
        step();

        // Branch taken coinciding with a hazard
        drive(0, 0, 0, 0, 6, 1, 1, 0, 0); step();
        drive(6, 1, 0, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();

        // Memory wait during a pending load-use hazard
        drive(0, 0, 0, 0, 7, 1, 1, 0, 0); step();
        drive(7, 1, 0, 0, 0, 0, 0, 0, 1); step(); step(); step();
        drive(7, 1, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();

        // Reset asserted mid-stall
        drive(0, 0, 0, 0, 8, 1, 0, 0, 0); step();
        drive(8, 1, 0, 0, 0, 0, 0, 0, 0); step();
        rst = 1'b1; step(); step();
        rst = 1'b0; step();

        // Matching index but source not read
        drive(0, 0, 0, 0, 9, 1, 1, 0, 0); step();
        drive(9, 0, 9, 0, 0, 0, 0, 0, 0); step(); step();

        // Random traffic over a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            step();
        end

        // Counter saturation
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 5, 1, 1, 0, 0); step();
            drive(5, 1, 0, 0, 0, 0, 0, 0, 0); step(); step();
        end
        chk("cnt_saturated", 32'(hz.stall_cnt), 32'(CNT_MAX));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
